// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
//   Direct-mapped, write-back, write-allocate L1 data cache controller.
//   Serves 32-bit CPU loads/stores from internal tag/data arrays. A miss
//   writes back a dirty victim line (WB), reads the new line (RD), installs
//   it (FILL), then re-evaluates the request in IDLE as a hit.
//
//   Optional feature: define DCACHE_STATS_EN to build the hit/miss
//   counters. Without it hit_cnt_o/miss_cnt_o are tied to zero.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   cpu_req_i/write_i      CPU request, 1=store 0=load
//   cpu_addr_i/data_i      byte address (bits[1:0] ignored), store data
//   cpu_data_o             load data (0 when not a hit)
//   cpu_stall_o            CPU must hold its request while high
//   mem_enable_o/write_o   memory request / write strobe (registered)
//   mem_addr_o/data_o      line address and write-back line (registered)
//   mem_ack_i              one-cycle memory acknowledge
//   mem_data_i             read line, valid the cycle after mem_ack_i
//   hit_cnt_o, miss_cnt_o  statistics counters
// ---------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int IDX_W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_write_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic         mem_ack_i,
    input  logic [255:0] mem_data_i,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 27 - IDX_W;

    typedef enum logic [1:0] {IDLE, WB, RD, FILL} state_t;

    state_t             state_reg;
    logic [LINES-1:0]   valid_reg;
    logic [LINES-1:0]   dirty_reg;
    // Hits are zero-latency, so the arrays are read asynchronously.
    logic [TAG_W-1:0]   tag_reg  [LINES];
    logic [255:0]       line_reg [LINES];

    logic [IDX_W-1:0]   miss_idx_reg;
    logic [TAG_W-1:0]   miss_tag_reg;
    logic               mem_enable_reg;
    logic               mem_write_reg;
    logic [31:0]        mem_addr_reg;
    logic [255:0]       mem_data_reg;

    logic [2:0]         req_word;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit;
    logic               idle;
    logic               miss_start;
    logic               write_hit;
    logic               fill;
    logic               addr_lsb_unused;

    assign req_word        = cpu_addr_i[4:2];
    assign req_idx         = cpu_addr_i[4+IDX_W:5];
    assign req_tag         = cpu_addr_i[31:5+IDX_W];
    assign addr_lsb_unused = &{1'b0, cpu_addr_i[1:0]};

    assign hit        = cpu_req_i & valid_reg[req_idx] & (tag_reg[req_idx] == req_tag);
    assign idle       = (state_reg == IDLE);
    assign miss_start = idle & cpu_req_i & ~hit;
    assign write_hit  = idle & hit & cpu_write_i;
    assign fill       = (state_reg == FILL);

    assign cpu_data_o   = hit ? line_reg[req_idx][{req_word, 5'b0} +: 32] : 32'd0;
    assign cpu_stall_o  = idle ? (cpu_req_i & ~hit) : 1'b1;
    assign mem_enable_o = mem_enable_reg;
    assign mem_write_o  = mem_write_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_data_o   = mem_data_reg;

    // Per-line valid/dirty flags: only these need clearing on reset.
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line_state
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_reg[gi] <= 1'b0;
                    dirty_reg[gi] <= 1'b0;
                end else if (fill && miss_idx_reg == IDX_W'(gi)) begin
                    valid_reg[gi] <= 1'b1;
                    dirty_reg[gi] <= 1'b0;
                end else if (write_hit && req_idx == IDX_W'(gi)) begin
                    dirty_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Tag/data arrays. A line installed during FILL is only trusted once its
    // valid bit is set, so these need no reset.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            line_reg[miss_idx_reg] <= mem_data_i;
            tag_reg[miss_idx_reg]  <= miss_tag_reg;
        end else if (write_hit) begin
            line_reg[req_idx][{req_word, 5'b0} +: 32] <= cpu_data_i;
        end
    end

    // Miss FSM with registered memory-side outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            miss_idx_reg   <= '0;
            miss_tag_reg   <= '0;
            mem_enable_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_data_reg   <= 256'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (miss_start) begin
                        // Latch the index/tag so the miss completes even if
                        // the CPU drops its request meanwhile.
                        miss_idx_reg   <= req_idx;
                        miss_tag_reg   <= req_tag;
                        mem_enable_reg <= 1'b1;
                        if (valid_reg[req_idx] && dirty_reg[req_idx]) begin
                            state_reg     <= WB;
                            mem_write_reg <= 1'b1;
                            mem_addr_reg  <= {tag_reg[req_idx], req_idx, 5'b0};
                            mem_data_reg  <= line_reg[req_idx];
                        end else begin
                            state_reg     <= RD;
                            mem_write_reg <= 1'b0;
                            mem_addr_reg  <= {req_tag, req_idx, 5'b0};
                        end
                    end
                end
                WB: begin
                    // Enable stays high into RD; the memory ignores it during
                    // its final cycle, so no gap state is required.
                    if (mem_ack_i) begin
                        state_reg     <= RD;
                        mem_write_reg <= 1'b0;
                        mem_addr_reg  <= {miss_tag_reg, miss_idx_reg, 5'b0};
                    end
                end
                RD: begin
                    if (mem_ack_i) begin
                        state_reg      <= FILL;
                        mem_enable_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic        fill_done_reg;
    logic [31:0] hit_cnt_reg;
    logic [31:0] miss_cnt_reg;

    // fill_done_reg marks the IDLE cycle that re-evaluates a completed miss;
    // that hit is not counted as a separate hit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_done_reg <= 1'b0;
            hit_cnt_reg   <= 32'd0;
            miss_cnt_reg  <= 32'd0;
        end else begin
            fill_done_reg <= fill;
            if (idle && hit && !fill_done_reg)
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            if (miss_start)
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_reg;
    assign miss_cnt_o = miss_cnt_reg;
`else
    assign hit_cnt_o  = 32'd0;
    assign miss_cnt_o = 32'd0;
`endif

endmodule
